// File: rtl/rgb2ycbcr_pkg.sv
// rgb2ycbcr_pkg: shared coefficients, offsets, clamp limits and pixel types
// for the RGB to BT.601 YCbCr converter.
package rgb2ycbcr_pkg;

  localparam logic [7:0] K_YR  = 8'd66;
  localparam logic [7:0] K_YG  = 8'd129;
  localparam logic [7:0] K_YB  = 8'd25;
  localparam logic [7:0] K_CBR = 8'd38;
  localparam logic [7:0] K_CBG = 8'd74;
  localparam logic [7:0] K_CBB = 8'd112;
  localparam logic [7:0] K_CRR = 8'd112;
  localparam logic [7:0] K_CRG = 8'd94;
  localparam logic [7:0] K_CRB = 8'd18;

  localparam logic [7:0] Y_OFS = 8'd16;
  localparam logic [7:0] C_OFS = 8'd128;
  localparam logic [7:0] RND   = 8'd128;

  localparam logic [7:0] LIM_LO   = 8'd16;
  localparam logic [7:0] LIM_Y_HI = 8'd235;
  localparam logic [7:0] LIM_C_HI = 8'd240;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  function automatic logic [15:0] mul8(
    input logic [7:0] a,
    input logic [7:0] k
  );
    return {8'd0, a} * {8'd0, k};
  endfunction

  function automatic logic signed [17:0] sx(
    input logic [15:0] v
  );
    return $signed({2'b00, v});
  endfunction

  function automatic logic signed [9:0] shr8(
    input logic signed [17:0] v
  );
    return 10'(v >>> 8);
  endfunction

endpackage

// File: rtl/ycbcr_clamp.sv
// ycbcr_clamp: saturate a signed 10-bit value into [lo,hi] as unsigned 8-bit.
// Both ends saturate; nothing wraps.
module ycbcr_clamp (
  input  logic signed [9:0] i_val,
  input  logic        [7:0] i_lo,
  input  logic        [7:0] i_hi,
  output logic        [7:0] o_val
);

  logic signed [9:0] w_lo;
  logic signed [9:0] w_hi;

  assign w_lo = $signed({2'b00, i_lo});
  assign w_hi = $signed({2'b00, i_hi});

  always_comb begin
    o_val = i_val[7:0];
    unique case (1'b1)
      (i_val < w_lo): o_val = i_lo;
      (i_val > w_hi): o_val = i_hi;
      default:        o_val = i_val[7:0];
    endcase
  end

endmodule

// File: rtl/rgb2ycbcr.sv
// rgb2ycbcr: 3-stage RGB to BT.601 YCbCr converter with valid/ready stall.
// Define RGB2YCBCR_CHROMA_422_EN for 4:2:2 chroma pair averaging.
module rgb2ycbcr
  import rgb2ycbcr_pkg::*;
#(
  parameter int CLAMP_STUDIO = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic       vld_i,
  output logic       rdy_o,
  input  logic       sol_i,
  output logic [7:0] y,
  output logic [7:0] cb,
  output logic [7:0] cr,
  output logic       vld_o,
  output logic       c_vld_o,
  input  logic       rdy_i
);

  logic w_en;
  logic w_acc;
  rgb_t w_px;

  logic        r_v1;
  logic [15:0] r_yr, r_yg, r_yb;
  logic [15:0] r_cbr, r_cbg, r_cbb;
  logic [15:0] r_crr, r_crg, r_crb;

  logic signed [17:0] w_ys, w_cbs, w_crs;
  logic               r_v2;
  logic signed [9:0]  r_ys, r_cbs, r_crs;

  logic signed [9:0] w_yo, w_cbo, w_cro;
  logic [7:0]        w_lo, w_yhi, w_chi;
  ycc_t              w_q;

  logic       r_vld;
  logic [7:0] r_y;

  // The whole pipe moves as one; bubbles are kept in place.
  assign w_en  = !r_vld || rdy_i;
  assign rdy_o = w_en;
  assign w_acc = vld_i && w_en;
  assign w_px  = '{r: r, g: g, b: b};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1  <= 1'b0;
      r_yr  <= '0;
      r_yg  <= '0;
      r_yb  <= '0;
      r_cbr <= '0;
      r_cbg <= '0;
      r_cbb <= '0;
      r_crr <= '0;
      r_crg <= '0;
      r_crb <= '0;
    end else if (w_en) begin
      r_v1  <= vld_i;
      r_yr  <= mul8(w_px.r, K_YR);
      r_yg  <= mul8(w_px.g, K_YG);
      r_yb  <= mul8(w_px.b, K_YB);
      r_cbr <= mul8(w_px.r, K_CBR);
      r_cbg <= mul8(w_px.g, K_CBG);
      r_cbb <= mul8(w_px.b, K_CBB);
      r_crr <= mul8(w_px.r, K_CRR);
      r_crg <= mul8(w_px.g, K_CRG);
      r_crb <= mul8(w_px.b, K_CRB);
    end
  end

  assign w_ys  = sx(r_yr) + sx(r_yg)
               + sx(r_yb) + sx({8'd0, RND});
  assign w_cbs = sx(r_cbb) - sx(r_cbr)
               - sx(r_cbg) + sx({8'd0, RND});
  assign w_crs = sx(r_crr) - sx(r_crg)
               - sx(r_crb) + sx({8'd0, RND});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2  <= 1'b0;
      r_ys  <= '0;
      r_cbs <= '0;
      r_crs <= '0;
    end else if (w_en) begin
      r_v2  <= r_v1;
      r_ys  <= shr8(w_ys);
      r_cbs <= shr8(w_cbs);
      r_crs <= shr8(w_crs);
    end
  end

  assign w_yo  = r_ys  + $signed({2'b00, Y_OFS});
  assign w_cbo = r_cbs + $signed({2'b00, C_OFS});
  assign w_cro = r_crs + $signed({2'b00, C_OFS});

  assign w_lo  = (CLAMP_STUDIO != 0) ? LIM_LO   : 8'd0;
  assign w_yhi = (CLAMP_STUDIO != 0) ? LIM_Y_HI : 8'd255;
  assign w_chi = (CLAMP_STUDIO != 0) ? LIM_C_HI : 8'd255;

  ycbcr_clamp u_clamp_y (
    .i_val (w_yo),
    .i_lo  (w_lo),
    .i_hi  (w_yhi),
    .o_val (w_q.y)
  );

  ycbcr_clamp u_clamp_cb (
    .i_val (w_cbo),
    .i_lo  (w_lo),
    .i_hi  (w_chi),
    .o_val (w_q.cb)
  );

  ycbcr_clamp u_clamp_cr (
    .i_val (w_cro),
    .i_lo  (w_lo),
    .i_hi  (w_chi),
    .o_val (w_q.cr)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= 1'b0;
      r_y   <= '0;
    end else if (w_en) begin
      r_vld <= r_v2;
      r_y   <= r_v2 ? w_q.y : 8'd0;
    end
  end

  assign vld_o = r_vld;
  assign y     = r_y;

`ifdef RGB2YCBCR_CHROMA_422_EN

  logic       w_odd;
  logic       r_par;
  logic       r_o1, r_o2;
  logic [7:0] r_cb, r_cr;
  logic [7:0] r_sc_cb, r_sc_cr;
  logic       r_cvld;
  logic [8:0] w_cba, w_cra;
  logic       w_unused;

  // A start-of-line pixel is always even, so any unpaired chroma is dropped.
  assign w_odd = !sol_i && r_par;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par <= 1'b0;
      r_o1  <= 1'b0;
      r_o2  <= 1'b0;
    end else if (w_en) begin
      if (w_acc) begin
        r_par <= !w_odd;
      end
      r_o1 <= w_odd;
      r_o2 <= r_o1;
    end
  end

  assign w_cba = {1'b0, r_sc_cb} + {1'b0, w_q.cb} + 9'd1;
  assign w_cra = {1'b0, r_sc_cr} + {1'b0, w_q.cr} + 9'd1;
  assign w_unused = w_cba[0] ^ w_cra[0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cb    <= '0;
      r_cr    <= '0;
      r_cvld  <= 1'b0;
      r_sc_cb <= '0;
      r_sc_cr <= '0;
    end else if (w_en) begin
      r_cb   <= 8'd0;
      r_cr   <= 8'd0;
      r_cvld <= 1'b0;
      if (r_v2 && !r_o2) begin
        r_sc_cb <= w_q.cb;
        r_sc_cr <= w_q.cr;
      end
      if (r_v2 && r_o2) begin
        r_cb   <= w_cba[8:1];
        r_cr   <= w_cra[8:1];
        r_cvld <= 1'b1;
      end
    end
  end

  assign cb      = r_cb;
  assign cr      = r_cr;
  assign c_vld_o = r_cvld;

`else

  logic [7:0] r_cb, r_cr;
  logic       w_unused;

  assign w_unused = sol_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cb <= '0;
      r_cr <= '0;
    end else if (w_en) begin
      r_cb <= r_v2 ? w_q.cb : 8'd0;
      r_cr <= r_v2 ? w_q.cr : 8'd0;
    end
  end

  assign cb      = r_cb;
  assign cr      = r_cr;
  assign c_vld_o = r_vld;

`endif

endmodule

// File: doc/rgb2ycbcr.md
Name: rgb2ycbcr

Overview:
- Forward colour-space converter for the encoder path: 8-bit RGB pixels in, 8-bit BT.601 studio-range Y/Cb/Cr out.
- Inverse of the decoder-side YCbCr-to-RGB stage; feeds the level-shift/DCT front end.
- Three-stage pipeline with valid/ready handshakes on both sides, so the block accepts back-pressure from the block buffer.

Parameters:
- CLAMP_STUDIO, 1: 1 = clamp Y to [16,235] and Cb/Cr to [16,240]; 0 = clamp all outputs to [0,255].

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- r, g, b  in  8 each  unsigned input pixel
- vld_i  in  1  input pixel valid
- rdy_o  out  1  block can accept a pixel this cycle
- sol_i  in  1  start of line, qualified by vld_i&&rdy_o (used only with the optional feature)
- y, cb, cr  out  8 each  unsigned output pixel
- vld_o  out  1  output valid
- c_vld_o  out  1  cb/cr carry meaningful chroma this beat
- rdy_i  in  1  downstream accepts the output

Behaviour:
- Reset is asynchronous on negedge rstn. All pipeline registers, valid bits, y/cb/cr, vld_o, c_vld_o and the parity state clear to 0. rdy_o is 1 immediately after reset.
- Global advance: en = !vld_o || rdy_i, and rdy_o = en (combinational).
- When en=0, every stage holds and outputs stay stable.
- Bubbles are not collapsed; a stage's valid bit moves with its data.
- A transfer occurs on vld_i&&rdy_o at input and on vld_o&&rdy_i at output.
- Latency is 3 accepted cycles from input transfer to vld_o, with no stalls. Throughput is 1 pixel/clk.
- S1: register nine products as 16-bit unsigned:
  - Y: 66R, 129G, 25B
  - Cb: 38R, 74G, 112B
  - Cr: 112R, 94G, 18B
- S2: form 18-bit signed sums and add 128:
  - ys = 66R+129G+25B+128
  - cbs = -38R-74G+112B+128
  - crs = 112R-94G-18B+128
  - Then apply an arithmetic >>8 to each.
- S3: add offsets (+16 for Y, +128 for Cb/Cr), clamp per CLAMP_STUDIO, and register into y/cb/cr.
- Clamp saturates both low and high; no wrap-around is permitted.
- When the S3 valid bit is 0, y/cb/cr drive 0 (the codebase zero-on-invalid rule).
- Without the optional feature, c_vld_o equals vld_o.
- Reset asserted mid-stream discards all in-flight pixels; no partial output appears after reset release.
- vld_i is ignored while rdy_o=0; the upstream must hold its data.
- A simultaneous input and output transfer is the normal streaming case and is handled without loss.

Optional Feature:
- Macro: RGB2YCBCR_CHROMA_422_EN
- With the macro:
  - A parity bit toggles on each input transfer. It is forced to even when sol_i is set on an accepted pixel, so that pixel is even.
  - Even pixel: its S3 Cb/Cr are held in a side register; the output beat has c_vld_o=0 and cb=cr=0.
  - Odd pixel: output cb=(cb_even+cb_odd+1)>>1, likewise for cr, with c_vld_o=1.
  - Y is unaffected.
  - A line ending on an even pixel leaves its chroma unpaired; it is discarded at the next sol_i.
  - Parity advances only with en=1.
- Without the macro: sol_i is unused, there is no side register, and c_vld_o=vld_o.

Decomposition:
- Shared package holds:
  - coefficient constants: K_YR=66, K_YG=129, K_YB=25, K_CBR=38, K_CBG=74, K_CBB=112, K_CRR=112, K_CRG=94, K_CRB=18
  - offsets: Y_OFS=16, C_OFS=128, RND=128
  - clamp limits: 16, 235, 240
  - a pixel struct typedef {r,g,b} / {y,cb,cr} of 8-bit fields
- One natural sub-module, ycbcr_clamp: a signed 10-bit value plus lo/hi bounds in, unsigned 8-bit saturated value out; instantiated 3 times in S3.

Test Plan:
- Reset, then stream (0,0,0), (255,255,255), (255,0,0), (0,0,255) with rdy_i=1 → after 3 cycles, one per clk: (16,128,128), (235,128,128), (82,90,240), (41,240,110).
- Back-pressure: stream 8 random pixels, holding rdy_i=0 for 4 cycles mid-burst → rdy_o low during the stall, outputs stable, no loss or duplication, order preserved against the software model.
- Clamp: CLAMP_STUDIO=0 vs 1, sweep all R=G=B in 0..255 → Y within bounds every beat, Cb=Cr=128 for each grey.
- Reset mid-stream: assert rstn=0 with 3 pixels in flight → outputs 0 and vld_o=0 asynchronously; after release, the first output is the first new pixel only.
- Bubble pattern: vld_i toggling 1,0,1,0 → vld_o shows the same pattern shifted by 3 cycles, with y/cb/cr=0 on invalid beats.
- With RGB2YCBCR_CHROMA_422_EN:
  - sol_i then pixels red, blue → second output beat cb=(90+240+1)>>1=165, cr=(240+110+1)>>1=175, c_vld_o=1; first beat c_vld_o=0.
  - sol_i on an odd position resets parity.
